// File: rtl/sram_port_ctrl_pkg.sv
// Shared types and default geometry for the single-port SRAM controller.
package sram_port_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF     = 10;
   localparam int unsigned DATA_W_DEF     = 128;
   localparam int unsigned MASK_W_DEF     = 16;
   localparam int unsigned RESP_DEPTH_DEF = 3;
   localparam int unsigned LANE_W         = DATA_W_DEF / MASK_W_DEF;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

endpackage

// File: rtl/sram_port_ctrl_resp_fifo.sv
// Read-response FIFO: DEPTH x DATA_W, occupancy count, push and pop honoured in the same cycle.
module sram_port_ctrl_resp_fifo
   import sram_port_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = RESP_DEPTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] pop_data_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Pointer wrap is explicit because DEPTH need not be a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Valid/ready front end for an RW0-style single-port SRAM macro with in-order read responses.
// Optional zero-fill sweep after reset: SRAM_PORT_CTRL_ZERO_INIT_EN.
module sram_port_ctrl
   import sram_port_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MASK_W     = MASK_W_DEF,
   parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_en,
   output logic              ram_wmode,
   output logic [MASK_W-1:0] ram_wmask,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   state_e            state_q, state_d;
   logic              cap_pend_q, cap_pend_d;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_pop;
   logic [SUM_W-1:0]  occupancy;

`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
   logic [ADDR_W-1:0] init_addr_q, init_addr_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
         state_q     <= ST_INIT;
         init_addr_q <= '0;
`else
         state_q     <= ST_IDLE;
`endif
         cap_pend_q  <= 1'b0;
      end else begin
`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
         init_addr_q <= init_addr_d;
`endif
         state_q     <= state_d;
         cap_pend_q  <= cap_pend_d;
      end
   end

   // Occupancy counts the read whose data lands next edge, so a credit is never oversold.
   always_comb begin
      state_d    = state_q;
      cap_pend_d = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b0;
      fifo_pop   = 1'b0;
      ram_en     = 1'b0;
      ram_wmode  = 1'b0;
      ram_addr   = '0;
      ram_wmask  = '0;
      ram_wdata  = '0;
      occupancy  = SUM_W'(fifo_count) + SUM_W'(cap_pend_q);
`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
      init_addr_d = init_addr_q;
`endif
      if (!reset) begin
         resp_valid = (fifo_count != '0);
         fifo_pop   = resp_valid & resp_ready;
         busy       = (state_q == ST_INIT) | cap_pend_q | resp_valid;
         case (state_q)
            ST_INIT: begin
`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
               ram_en      = 1'b1;
               ram_wmode   = 1'b1;
               ram_addr    = init_addr_q;
               ram_wmask   = '1;
               init_addr_d = init_addr_q + ADDR_W'(1);
               if (init_addr_q == '1) begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end
            default: begin
               req_ready = (occupancy < SUM_W'(RESP_DEPTH));
               if (req_valid && req_ready) begin
                  ram_en     = 1'b1;
                  ram_wmode  = req_write;
                  ram_addr   = req_addr;
                  ram_wmask  = req_wmask;
                  ram_wdata  = req_wdata;
                  cap_pend_d = ~req_write;
               end
            end
         endcase
      end
   end

   // Macro data is only stable the cycle after the read, so capture is unconditional.
   sram_port_ctrl_resp_fifo #(
      .DEPTH  (RESP_DEPTH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_resp_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (cap_pend_q),
      .push_data_i (ram_rdata),
      .pop_i       (fifo_pop),
      .pop_data_o  (resp_rdata),
      .count_o     (fifo_count)
   );

endmodule
